// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU encodings, register-zero index and the ID/EX control bundle.
package id_ex_stage_pkg;
  localparam int ALU_W = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;
  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             reg_dst;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational hazard when a load in the later stage targets a source of the earlier one.
//   ex_valid_i/ex_mem_read_i/ex_rt_i : producing load (valid, is-load, destination index)
//   id_valid_i/id_rs_i/id_rt_i/id_uses_rt_i : consuming instruction and its source indices
//   hazard_o : consumer must wait one cycle
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RADDR_W = 5
) (
  input  logic               ex_valid_i,
  input  logic               ex_mem_read_i,
  input  logic [RADDR_W-1:0] ex_rt_i,
  input  logic               id_valid_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  input  logic               id_uses_rt_i,
  output logic               hazard_o
);
  // $zero is never a real dependency, so a load into it cannot stall
  assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != RADDR_W'(REG_ZERO)) & id_valid_i &
                    ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with built-in load-use stall and bubble insertion.
//   Hold freezes the stage; Flush squashes the ID instruction; a load-use hazard inserts one bubble.
//   ID_* : decoded instruction from ID; IDE_* : registered copies for EX and forwarding.
//   Stall : combinational, holds PC and IF/ID; Bubble_Cnt : saturating count of load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = ALU_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Hold,
  input  logic               Flush,
  input  logic               ID_Valid,
  input  logic [RADDR_W-1:0] ID_Rs,
  input  logic [RADDR_W-1:0] ID_Rt,
  input  logic [RADDR_W-1:0] ID_Rd,
  input  logic               ID_UsesRt,
  input  logic [DATA_W-1:0]  ID_Data1,
  input  logic [DATA_W-1:0]  ID_Data2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PC4,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  output logic               IDE_Valid,
  output logic [RADDR_W-1:0] IDE_Rs,
  output logic [RADDR_W-1:0] IDE_Rt,
  output logic [RADDR_W-1:0] IDE_Rd,
  output logic [DATA_W-1:0]  IDE_Data1,
  output logic [DATA_W-1:0]  IDE_Data2,
  output logic [DATA_W-1:0]  IDE_Imm,
  output logic [DATA_W-1:0]  IDE_PC4,
  output logic               IDE_RegWrite,
  output logic               IDE_MemRead,
  output logic               IDE_MemWrite,
  output logic               IDE_MemToReg,
  output logic               IDE_ALUSrc,
  output logic               IDE_RegDst,
  output logic [ALUOP_W-1:0] IDE_ALUOp,
  output logic               Stall,
  output logic [CNT_W-1:0]   Bubble_Cnt
);
  logic               valid_q, valid_d;
  logic [RADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]  d1_q, d1_d, d2_q, d2_d, imm_q, imm_d, pc4_q, pc4_d;
  ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hazard, bubble;
  load_use_detect #(.RADDR_W(RADDR_W)) u_lud (
    .ex_valid_i   (valid_q),
    .ex_mem_read_i(ctrl_q.mem_read),
    .ex_rt_i      (rt_q),
    .id_valid_i   (ID_Valid),
    .id_rs_i      (ID_Rs),
    .id_rt_i      (ID_Rt),
    .id_uses_rt_i (ID_UsesRt),
    .hazard_o     (hazard)
  );
  assign id_ctrl = '{reg_write: ID_RegWrite, mem_read: ID_MemRead, mem_write: ID_MemWrite,
                     mem_to_reg: ID_MemToReg, alu_src: ID_ALUSrc, reg_dst: ID_RegDst,
                     alu_op: ID_ALUOp};
  // flush and load-use both load the same all-zero bubble; only a genuine hazard is counted
  assign bubble = Flush | hazard;
  assign Stall  = hazard & ~Flush & ~Hold;
  always_comb begin
    valid_d = Hold ? valid_q : ID_Valid & ~bubble;
    rs_d    = Hold ? rs_q    : bubble ? '0 : ID_Rs;
    rt_d    = Hold ? rt_q    : bubble ? '0 : ID_Rt;
    rd_d    = Hold ? rd_q    : bubble ? '0 : ID_Rd;
    d1_d    = Hold ? d1_q    : bubble ? '0 : ID_Data1;
    d2_d    = Hold ? d2_q    : bubble ? '0 : ID_Data2;
    imm_d   = Hold ? imm_q   : bubble ? '0 : ID_Imm;
    pc4_d   = Hold ? pc4_q   : bubble ? '0 : ID_PC4;
    ctrl_d  = Hold ? ctrl_q  : bubble ? CTRL_NOP : id_ctrl;
    cnt_d   = (Stall & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      ctrl_q  <= CTRL_NOP;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end
  assign IDE_Valid    = valid_q;
  assign IDE_Rs       = rs_q;
  assign IDE_Rt       = rt_q;
  assign IDE_Rd       = rd_q;
  assign IDE_Data1    = d1_q;
  assign IDE_Data2    = d2_q;
  assign IDE_Imm      = imm_q;
  assign IDE_PC4      = pc4_q;
  assign IDE_RegWrite = ctrl_q.reg_write;
  assign IDE_MemRead  = ctrl_q.mem_read;
  assign IDE_MemWrite = ctrl_q.mem_write;
  assign IDE_MemToReg = ctrl_q.mem_to_reg;
  assign IDE_ALUSrc   = ctrl_q.alu_src;
  assign IDE_RegDst   = ctrl_q.reg_dst;
  assign IDE_ALUOp    = ctrl_q.alu_op;
  assign Bubble_Cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven check of capture, load-use bubbles, flush, hold, saturation and reset.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Hold, Flush, ID_Valid, ID_UsesRt;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [31:0] ID_Data1, ID_Data2, ID_Imm, ID_PC4;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst;
  logic [3:0]  ID_ALUOp;
  logic        IDE_Valid;
  logic [4:0]  IDE_Rs, IDE_Rt, IDE_Rd;
  logic [31:0] IDE_Data1, IDE_Data2, IDE_Imm, IDE_PC4;
  logic        IDE_RegWrite, IDE_MemRead, IDE_MemWrite, IDE_MemToReg, IDE_ALUSrc, IDE_RegDst;
  logic [3:0]  IDE_ALUOp;
  logic        Stall;
  logic [2:0]  Bubble_Cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .Hold(Hold), .Flush(Flush), .ID_Valid(ID_Valid),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
    .ID_Data1(ID_Data1), .ID_Data2(ID_Data2), .ID_Imm(ID_Imm), .ID_PC4(ID_PC4),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
    .IDE_Valid(IDE_Valid), .IDE_Rs(IDE_Rs), .IDE_Rt(IDE_Rt), .IDE_Rd(IDE_Rd),
    .IDE_Data1(IDE_Data1), .IDE_Data2(IDE_Data2), .IDE_Imm(IDE_Imm), .IDE_PC4(IDE_PC4),
    .IDE_RegWrite(IDE_RegWrite), .IDE_MemRead(IDE_MemRead), .IDE_MemWrite(IDE_MemWrite),
    .IDE_MemToReg(IDE_MemToReg), .IDE_ALUSrc(IDE_ALUSrc), .IDE_RegDst(IDE_RegDst),
    .IDE_ALUOp(IDE_ALUOp), .Stall(Stall), .Bubble_Cnt(Bubble_Cnt)
  );

  typedef struct {
    logic hold, flush, valid; logic [4:0] rs, rt, rd; logic uses, rw, mr; logic [3:0] alu; logic [31:0] d1;
    logic st, ev; logic [4:0] ers, ert, erd; logic erw, emr; logic [3:0] ealu; logic [31:0] ed1; logic [2:0] ecnt;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // data2/imm/pc4 and mem_to_reg/alu_src are derived from d1 and mr so they are checkable from the table
  task automatic drive(input logic h, input logic f, input logic vl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic u, input logic rw, input logic mr, input logic [3:0] alu,
                       input logic [31:0] d1);
    Hold = h; Flush = f; ID_Valid = vl; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = u;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MemToReg = mr; ID_ALUSrc = mr; ID_MemWrite = 1'b0; ID_RegDst = 1'b0;
    ID_ALUOp = alu; ID_Data1 = d1; ID_Data2 = d1 + 32'd1; ID_Imm = d1 + 32'd2; ID_PC4 = d1 + 32'd4;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_valid"}, 32'(IDE_Valid), 32'd0);
    chk({tag, "_idx"}, {17'd0, IDE_Rs, IDE_Rt, IDE_Rd}, 32'd0);
    chk({tag, "_ctrl"}, {22'd0, IDE_RegWrite, IDE_MemRead, IDE_MemWrite, IDE_MemToReg, IDE_ALUSrc, IDE_RegDst, IDE_ALUOp}, 32'd0);
    chk({tag, "_data"}, IDE_Data1 | IDE_Data2 | IDE_Imm | IDE_PC4, 32'd0);
    chk({tag, "_stall"}, 32'(Stall), 32'd0);
  endtask

  initial begin
    //           h f v rs rt rd u rw mr alu d1        st ev ers ert erd erw emr ealu ed1      cnt
    v.push_back('{0,0,1, 3, 4, 6,1, 1, 0, 2,32'h11,    0, 1, 3, 4, 6, 1, 0, 2, 32'h11, 0});
    v.push_back('{0,0,1, 2, 5, 0,0, 1, 1, 0,32'h22,    0, 1, 2, 5, 0, 1, 1, 0, 32'h22, 0});
    v.push_back('{0,0,1, 5, 7, 8,1, 1, 0, 1,32'h33,    1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  1});
    v.push_back('{0,0,1, 5, 7, 8,1, 1, 0, 1,32'h33,    0, 1, 5, 7, 8, 1, 0, 1, 32'h33, 1});
    v.push_back('{0,0,1, 1, 5, 0,0, 1, 1, 0,32'h44,    0, 1, 1, 5, 0, 1, 1, 0, 32'h44, 1});
    v.push_back('{0,0,1, 6, 5, 9,0, 1, 0, 3,32'h55,    0, 1, 6, 5, 9, 1, 0, 3, 32'h55, 1});
    v.push_back('{0,0,1, 1, 0, 0,0, 1, 1, 0,32'h66,    0, 1, 1, 0, 0, 1, 1, 0, 32'h66, 1});
    v.push_back('{0,0,1, 0, 0, 3,1, 1, 0, 4,32'h77,    0, 1, 0, 0, 3, 1, 0, 4, 32'h77, 1});
    v.push_back('{0,0,1, 2, 5, 0,0, 1, 1, 0,32'h88,    0, 1, 2, 5, 0, 1, 1, 0, 32'h88, 1});
    v.push_back('{0,0,1, 9, 5, 4,1, 1, 0, 5,32'h99,    1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  2});
    v.push_back('{0,0,0, 5, 0, 0,0, 0, 0, 0,32'hAA,    0, 0, 5, 0, 0, 0, 0, 0, 32'hAA, 2});
    v.push_back('{0,0,1, 2, 5, 0,0, 1, 1, 0,32'hBB,    0, 1, 2, 5, 0, 1, 1, 0, 32'hBB, 2});
    v.push_back('{0,0,0, 5, 1, 2,1, 0, 0, 0,32'hCC,    0, 0, 5, 1, 2, 0, 0, 0, 32'hCC, 2});
    v.push_back('{0,0,1, 2, 5, 0,0, 1, 1, 0,32'hDD,    0, 1, 2, 5, 0, 1, 1, 0, 32'hDD, 2});
    v.push_back('{0,1,1, 5, 7, 8,1, 1, 0, 1,32'hEE,    0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  2});
    v.push_back('{0,0,1, 2, 5, 0,0, 1, 1, 0,32'h12,    0, 1, 2, 5, 0, 1, 1, 0, 32'h12, 2});
    v.push_back('{1,1,1, 5, 7, 8,1, 1, 0, 1,32'h13,    0, 1, 2, 5, 0, 1, 1, 0, 32'h12, 2});
    v.push_back('{1,1,1, 3, 3, 3,1, 1, 0, 6,32'h14,    0, 1, 2, 5, 0, 1, 1, 0, 32'h12, 2});
    v.push_back('{1,1,0, 5, 5, 5,1, 0, 1, 7,32'h15,    0, 1, 2, 5, 0, 1, 1, 0, 32'h12, 2});
    v.push_back('{0,1,1, 5, 7, 8,1, 1, 0, 1,32'h16,    0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  2});

    // reset with a live instruction presented: stage must still read as NOP
    rst_n = 1'b0;
    drive(0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 4'd0, 32'h0);
    ID_MemWrite = 1'b1; ID_RegDst = 1'b1;
    #1;
    chk_nop("rst_async");
    @(posedge clk); #1;
    chk_nop("rst_edge");
    chk("rst_cnt", 32'(Bubble_Cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rs", 32'(IDE_Rs), 32'd3);
    chk("rel_rw", 32'(IDE_RegWrite), 32'd1);
    chk("rel_mw_rd", {30'd0, IDE_MemWrite, IDE_RegDst}, 32'd3);
    chk("rel_pc4", IDE_PC4, 32'd4);

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      drive(v[i].hold, v[i].flush, v[i].valid, v[i].rs, v[i].rt, v[i].rd, v[i].uses, v[i].rw, v[i].mr, v[i].alu, v[i].d1);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(Stall), 32'(v[i].st));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(IDE_Valid), 32'(v[i].ev));
      chk($sformatf("v%0d_idx", i), {17'd0, IDE_Rs, IDE_Rt, IDE_Rd}, {17'd0, v[i].ers, v[i].ert, v[i].erd});
      chk($sformatf("v%0d_ctrl", i), {24'd0, IDE_RegWrite, IDE_MemRead, IDE_MemToReg, IDE_ALUSrc, IDE_ALUOp},
          {24'd0, v[i].erw, v[i].emr, v[i].emr, v[i].emr, v[i].ealu});
      chk($sformatf("v%0d_d1", i), IDE_Data1, v[i].ed1);
      chk($sformatf("v%0d_d2", i), IDE_Data2, v[i].ed1 == 0 ? 32'd0 : v[i].ed1 + 32'd1);
      chk($sformatf("v%0d_imm", i), IDE_Imm, v[i].ed1 == 0 ? 32'd0 : v[i].ed1 + 32'd2);
      chk($sformatf("v%0d_cnt", i), 32'(Bubble_Cnt), 32'(v[i].ecnt));
    end

    // drive the 3-bit counter past its ceiling: 2 -> 7 then stays at 7
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 5'd2, 5'd5, 5'd0, 0, 1, 1, 4'd0, 32'h40 + 32'(k));
      @(negedge clk);
      drive(0, 0, 1, 5'd5, 5'd7, 5'd8, 1, 1, 0, 4'd1, 32'h50);
      #1;
      chk($sformatf("sat%0d_stall", k), 32'(Stall), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_cnt", k), 32'(Bubble_Cnt), (k >= 5) ? 32'd7 : 32'(2 + k));
      chk($sformatf("sat%0d_rw", k), 32'(IDE_RegWrite), 32'd0);
    end

    // reset asserted while a stall is active
    @(negedge clk);
    drive(0, 0, 1, 5'd2, 5'd5, 5'd0, 0, 1, 1, 4'd0, 32'h60);
    @(negedge clk);
    drive(0, 0, 1, 5'd5, 5'd7, 5'd8, 1, 1, 0, 4'd1, 32'h61);
    #1;
    chk("mid_stall_pre", 32'(Stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_nop("mid_rst");
    chk("mid_rst_cnt", 32'(Bubble_Cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
